jk_cmd_sequencer: RTL and testbench

- Upstream driver for the jk_latch stage. It accepts latch commands (HOLD/RESET/SET/TOGGLE) over a valid/ready handshake and buffers them in a small FIFO.
- Each command is replayed as a timed J/K pulse into the latch.
- The latch Q output is sampled back and compared against an internal reference model, and a sticky mismatch flag reports any disagreement.
- The block is used both as a stimulus engine for latch labs and as an on-chip self-check.

---
 rtl/jk_pkg.sv | 29 ++
 rtl/jk_cmd_fifo.sv | 59 +++++
 rtl/jk_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// jk_pkg: shared types and constants for the jk_latch command sequencer.
//   op_t    - latch command encoding carried through the command FIFO
//   state_t - sequencer FSM states
//   J_LUT / K_LUT - J/K drive value for each op, indexed by the op encoding
package jk_pkg;

   typedef enum logic [1:0] {
      OP_HOLD   = 2'b00,
      OP_RESET  = 2'b01,
      OP_SET    = 2'b10,
      OP_TOGGLE = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SETTLE,
      ST_CHECK
   } state_t;

   // Bit n of each table is the drive value for op encoding n:
   // HOLD 0/0, RESET 0/1, SET 1/0, TOGGLE 1/1.
   localparam logic [3:0] J_LUT = 4'b1100;
   localparam logic [3:0] K_LUT = 4'b1010;

   // Width of the drive-cycle down-counter (DRIVE_CYCLES up to 15).
   localparam int CNT_W = 4;

endpackage

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: small synchronous FIFO for queued latch commands.
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, wdata  - write strobe and data (ignored when full)
//   pop, rdata   - read strobe (ignored when empty) and head-of-queue data
//   full, empty  - occupancy flags derived from the registered count
//   level        - current occupancy, 0..DEPTH
module jk_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [WIDTH-1:0]        wdata,
   input  logic                    pop,
   output logic [WIDTH-1:0]        rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // NOTE: the storage array has no reset; an entry is only ever read after
   // it has been written, and resetting it would cost a reset net per bit.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues latch commands and replays each one as a timed
// J/K pulse into a jk_latch, then checks the latch Q against a reference.
//   clk, rst_n           - clock, asynchronous active-low reset
//   cmd_valid, cmd_op    - command handshake input (op: HOLD/RESET/SET/TOGGLE)
//   cmd_ready            - FIFO not full
//   J, K                 - registered latch drives
//   q_in                 - latch Q feedback, synchronous to clk
//   busy                 - FSM active or commands queued
//   level                - FIFO occupancy
//   exp_q, exp_known     - reference-model Q and whether it is defined
//   done                 - one-cycle pulse at the end of each command's check
//   mismatch             - sticky Q disagreement flag
module jk_cmd_sequencer import jk_pkg::*; #(
   parameter int DEPTH        = 4,
   parameter int DRIVE_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   input  logic [1:0]              cmd_op,
   output logic                    cmd_ready,
   output logic                    J,
   output logic                    K,
   input  logic                    q_in,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    exp_q,
   output logic                    exp_known,
   output logic                    done,
   output logic                    mismatch
);

   state_t           state, state_next;
   op_t              op_reg, op_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             j_next, k_next;
   logic             exp_q_next, exp_known_next;
   logic             done_next, mismatch_next;
   logic             push, pop, full, empty;
   logic [1:0]       head;

   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign busy      = (state != ST_IDLE) || !empty;

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (cmd_op),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next     = state;
      op_next        = op_reg;
      cnt_next       = cnt;
      j_next         = J;
      k_next         = K;
      exp_q_next     = exp_q;
      exp_known_next = exp_known;
      done_next      = 1'b0;
      mismatch_next  = mismatch;
      pop            = 1'b0;

      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               op_next    = op_t'(head);
               j_next     = J_LUT[head];
               k_next     = K_LUT[head];
               cnt_next   = CNT_W'(DRIVE_CYCLES - 1);
               state_next = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (cnt == '0) begin
               j_next     = 1'b0;
               k_next     = 1'b0;
               state_next = ST_SETTLE;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            // The model advances here so CHECK compares against the
            // post-command value while the latch has had a quiet cycle.
            case (op_reg)
               OP_RESET: begin
                  exp_q_next     = 1'b0;
                  exp_known_next = 1'b1;
               end
               OP_SET: begin
                  exp_q_next     = 1'b1;
                  exp_known_next = 1'b1;
               end
               OP_TOGGLE: begin
                  if (exp_known) exp_q_next = !exp_q;
               end
               default: ;
            endcase
            state_next = ST_CHECK;
         end
         ST_CHECK: begin
            // An undefined model never flags: HOLD/TOGGLE before the first
            // SET/RESET cannot be checked.
            if (exp_known && (q_in != exp_q)) mismatch_next = 1'b1;
            done_next  = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         op_reg    <= OP_HOLD;
         cnt       <= '0;
         J         <= 1'b0;
         K         <= 1'b0;
         exp_q     <= 1'b0;
         exp_known <= 1'b0;
         done      <= 1'b0;
         mismatch  <= 1'b0;
      end else begin
         state     <= state_next;
         op_reg    <= op_next;
         cnt       <= cnt_next;
         J         <= j_next;
         K         <= k_next;
         exp_q     <= exp_q_next;
         exp_known <= exp_known_next;
         done      <= done_next;
         mismatch  <= mismatch_next;
      end
   end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: directed bench for jk_cmd_sequencer with a clocked
// JK latch model on q_in (overridable to force Q values).
module tb_jk_cmd_sequencer;
   import jk_pkg::*;

   localparam int DEPTH        = 4;
   localparam int DRIVE_CYCLES = 1;
   localparam int LW           = $clog2(DEPTH) + 1;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [1:0]    cmd_op    = 2'b00;
   logic          cmd_ready, J, K, q_in, busy;
   logic          exp_q, exp_known, done, mismatch;
   logic [LW-1:0] level;

   logic lq        = 1'b0;
   logic force_en  = 1'b0;
   logic force_val = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [1:0] pulses [$];
   logic       prev_act = 1'b0;
   int         done_cnt = 0;

   jk_cmd_sequencer #(
      .DEPTH        (DEPTH),
      .DRIVE_CYCLES (DRIVE_CYCLES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_ready (cmd_ready),
      .J         (J),
      .K         (K),
      .q_in      (q_in),
      .busy      (busy),
      .level     (level),
      .exp_q     (exp_q),
      .exp_known (exp_known),
      .done      (done),
      .mismatch  (mismatch)
   );

   always #5 clk = ~clk;

   // Clocked JK latch model driven by the DUT.
   always @(posedge clk) begin
      case ({J, K})
         2'b01:   lq <= 1'b0;
         2'b10:   lq <= 1'b1;
         2'b11:   lq <= ~lq;
         default: ;
      endcase
   end

   assign q_in = force_en ? force_val : lq;

   // Record each J/K pulse (rising activity) and count done pulses.
   always @(negedge clk) begin
      if ((J || K) && !prev_act) pulses.push_back({J, K});
      prev_act <= J || K;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_op(input logic [1:0] op, output int stalls);
      stalls    = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      while (!cmd_ready && stalls < 50) begin
         tick();
         stalls++;
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, busy, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int st;
      int p0;
      int d0;
      logic [1:0] exp_p [5];
      exp_p = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b10};

      // Reset then idle.
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("rst_j", J, 0);
      check("rst_k", K, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_level", level, 0);
      check("rst_known", exp_known, 0);
      check("rst_expq", exp_q, 0);
      check("rst_mismatch", mismatch, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);

      // Single SET: cycle-by-cycle latency.
      d0 = done_cnt;
      push_op(OP_SET, st);
      check("set_level_t0", level, 1);
      check("set_j_t0", J, 0);
      check("set_busy_t0", busy, 1);
      tick();
      check("set_j_t1", J, 1);
      check("set_k_t1", K, 0);
      check("set_level_t1", level, 0);
      tick();
      check("set_j_t2", J, 0);
      check("set_k_t2", K, 0);
      tick();
      check("set_done_t3", done, 0);
      check("set_expq_t3", exp_q, 1);
      check("set_known_t3", exp_known, 1);
      tick();
      check("set_done_t4", done, 1);
      check("set_mismatch_t4", mismatch, 0);
      tick();
      check("set_done_t5", done, 0);
      check("set_busy_t5", busy, 0);
      check("set_done_count", done_cnt - d0, 1);

      // Burst of DEPTH+1 ops behind a HOLD that keeps the FSM busy.
      p0 = pulses.size();
      push_op(OP_HOLD, st);
      push_op(OP_SET, st);
      push_op(OP_TOGGLE, st);
      push_op(OP_TOGGLE, st);
      push_op(OP_RESET, st);
      check("burst_level_full", level, 4);
      check("burst_ready_low", cmd_ready, 0);
      push_op(OP_SET, st);
      check("burst_stalls", st, 1);
      check("burst_level_refill", level, 4);
      wait_idle("burst");
      check("burst_npulses", pulses.size() - p0, 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("burst_pulse%0d", i), pulses[p0 + i], exp_p[i]);
      end
      check("burst_expq", exp_q, 1);
      check("burst_mismatch", mismatch, 0);

      // TOGGLE with an unknown model and Q forced high.
      do_reset();
      force_en  = 1'b1;
      force_val = 1'b1;
      p0 = pulses.size();
      push_op(OP_TOGGLE, st);
      wait_idle("tog_unknown");
      check("tog_npulses", pulses.size() - p0, 1);
      check("tog_pulse", pulses[p0], 2'b11);
      check("tog_known", exp_known, 0);
      check("tog_expq", exp_q, 0);
      check("tog_mismatch", mismatch, 0);

      // Fault injection: SET with Q tied low, then correct commands.
      force_val = 1'b0;
      push_op(OP_SET, st);
      wait_idle("fault_set");
      check("fault_mismatch", mismatch, 1);
      force_en = 1'b0;
      push_op(OP_RESET, st);
      wait_idle("fault_reset");
      push_op(OP_SET, st);
      wait_idle("fault_set2");
      check("fault_q_agrees", q_in, 1);
      check("fault_expq", exp_q, 1);
      check("fault_sticky", mismatch, 1);
      do_reset();
      check("fault_cleared", mismatch, 0);

      // Reset asserted mid-DRIVE with two ops still queued.
      push_op(OP_SET, st);
      push_op(OP_TOGGLE, st);
      push_op(OP_RESET, st);
      push_op(OP_HOLD, st);
      tick();
      tick();
      check("mid_j_pre", J, 1);
      check("mid_k_pre", K, 1);
      check("mid_level_pre", level, 2);
      d0 = done_cnt;
      p0 = pulses.size();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_j_rst", J, 0);
      check("mid_k_rst", K, 0);
      check("mid_level_rst", level, 0);
      check("mid_busy_rst", busy, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check("mid_no_done", done_cnt - d0, 0);
      check("mid_no_pulse", pulses.size() - p0, 0);
      check("mid_level_post", level, 0);
      check("mid_busy_post", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
